// File: rtl/ifetch_if.sv
// Fetch-stage bus bundle: instruction-cache request/response, BHT lookup,
// instruction-queue head towards decode, and the redirect from commit.
interface ifetch_if;
   logic        icache_req;
   logic [31:0] icache_addr;
   logic        icache_valid;
   logic [31:0] icache_inst;
   logic [7:0]  bht_index;
   logic        bht_taken;
   logic        iq_valid;
   logic [31:0] iq_inst;
   logic [31:0] iq_pc;
   logic        iq_pred_taken;
   logic        iq_ready;
   logic        flush;
   logic [31:0] flush_pc;

   modport master (
      output icache_req, icache_addr, bht_index,
      output iq_valid, iq_inst, iq_pc, iq_pred_taken,
      input  icache_valid, icache_inst, bht_taken, iq_ready, flush, flush_pc
   );

   modport slave (
      input  icache_req, icache_addr, bht_index,
      input  iq_valid, iq_inst, iq_pc, iq_pred_taken,
      output icache_valid, icache_inst, bht_taken, iq_ready, flush, flush_pc
   );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding icache request, JAL/B-type next-PC prediction,
// and an instruction queue to decode. Macro IFETCH_PREDICT_EN enables BHT use for B-type.
module ifetch #(
   parameter int          QUEUE_DEPTH_LOG = 3,
   parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
   input logic      clk,
   input logic      rst,
   input logic      rdy,
   ifetch_if.master bus
);
   localparam int CW = QUEUE_DEPTH_LOG + 1;
   localparam int DEPTH = 1 << QUEUE_DEPTH_LOG;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_BLOCK = 2'd2
   } state_t;

   function automatic logic [31:0] imm_j(input logic [31:0] i);
      return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] i);
      return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
   endfunction

   state_t                     state_r, state_s;
   logic [31:0]                pc_r, pc_s;
   logic                       req_r, req_s;
   logic [31:0]                addr_r, addr_s;
   logic [CW-1:0]              count_r, count_s, count_after_pop_s;
   logic [QUEUE_DEPTH_LOG-1:0] head_r, head_s, tail_r, tail_s;
   logic                       pop_s, push_s, pred_s, bht_pred_s;
   logic [64:0]                push_data_s;
   logic [64:0]                mem_r [DEPTH];
   logic [64:0]                head_entry_s;

`ifdef IFETCH_PREDICT_EN
   assign bht_pred_s    = bus.bht_taken;
   assign bus.bht_index = addr_r[9:2];
`else
   logic unused_bht_s;
   assign unused_bht_s  = bus.bht_taken;
   assign bht_pred_s    = 1'b0;
   assign bus.bht_index = 8'd0;
`endif

   assign pop_s             = rdy && (count_r != CW'(0)) && bus.iq_ready;
   assign count_after_pop_s = count_r - CW'(pop_s);

   // Next-state, next-PC and queue pointer logic; flush overrides everything.
   always_comb begin
      state_s     = state_r;
      pc_s        = pc_r;
      req_s       = req_r;
      addr_s      = addr_r;
      push_s      = 1'b0;
      pred_s      = 1'b0;
      count_s     = count_r;
      head_s      = head_r;
      tail_s      = tail_r;
      if (!rdy) begin
         state_s = state_r;
      end else if (bus.flush) begin
         count_s = CW'(0);
         head_s  = '0;
         tail_s  = '0;
         pc_s    = bus.flush_pc;
         req_s   = 1'b0;
         state_s = S_REQ;
      end else begin
         case (state_r)
            S_REQ: begin
               if (count_after_pop_s < DEPTH_C) begin
                  req_s   = 1'b1;
                  addr_s  = pc_r;
                  state_s = S_WAIT;
               end else begin
                  state_s = S_REQ;
               end
            end
            S_WAIT: begin
               if (bus.icache_valid && req_r) begin
                  req_s  = 1'b0;
                  push_s = 1'b1;
                  case (bus.icache_inst[6:0])
                     OP_JAL: begin
                        pred_s  = 1'b1;
                        pc_s    = pc_r + imm_j(bus.icache_inst);
                        state_s = S_REQ;
                     end
                     OP_BRANCH: begin
                        pred_s  = bht_pred_s;
                        pc_s    = bht_pred_s ? pc_r + imm_b(bus.icache_inst) : pc_r + 32'd4;
                        state_s = S_REQ;
                     end
                     // Indirect target is unknown here: park until commit redirects.
                     OP_JALR: begin
                        pred_s  = 1'b0;
                        state_s = S_BLOCK;
                     end
                     default: begin
                        pred_s  = 1'b0;
                        pc_s    = pc_r + 32'd4;
                        state_s = S_REQ;
                     end
                  endcase
               end else begin
                  state_s = S_WAIT;
               end
            end
            S_BLOCK: state_s = S_BLOCK;
            default: state_s = S_REQ;
         endcase
         count_s = count_after_pop_s + CW'(push_s);
         head_s  = pop_s  ? head_r + 1'b1 : head_r;
         tail_s  = push_s ? tail_r + 1'b1 : tail_r;
      end
   end

   assign push_data_s = {bus.icache_inst, pc_r, pred_s};

   // Control and pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_REQ;
         pc_r    <= RESET_PC;
         req_r   <= 1'b0;
         addr_r  <= RESET_PC;
         count_r <= CW'(0);
         head_r  <= '0;
         tail_r  <= '0;
      end else begin
         state_r <= state_s;
         pc_r    <= pc_s;
         req_r   <= req_s;
         addr_r  <= addr_s;
         count_r <= count_s;
         head_r  <= head_s;
         tail_r  <= tail_s;
      end
   end

   // Queue storage; contents are don't-care while count marks them empty.
   always_ff @(posedge clk) begin
      if (!rst && push_s) begin
         mem_r[tail_r] <= push_data_s;
      end
   end

   assign head_entry_s      = (count_r != CW'(0)) ? mem_r[head_r] : 65'd0;
   assign bus.icache_req    = req_r;
   assign bus.icache_addr   = addr_r;
   assign bus.iq_valid      = (count_r != CW'(0));
   assign bus.iq_inst       = head_entry_s[64:33];
   assign bus.iq_pc         = head_entry_s[32:1];
   assign bus.iq_pred_taken = head_entry_s[0];
endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch with a hand-driven single-cycle icache.
module tb_ifetch;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rdy = 1'b1;
   int   n_cmp = 0;
   int   n_fail = 0;

   ifetch_if bus ();

   ifetch #(.QUEUE_DEPTH_LOG(3), .RESET_PC(32'h0000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (bus)
   );

   always #5 clk = ~clk;

`ifdef IFETCH_PREDICT_EN
   localparam logic        EXP_BR_PRED = 1'b1;
   localparam logic [31:0] EXP_BR_NEXT = 32'h0000_003C;
   localparam logic [7:0]  EXP_BR_IDX  = 8'h10;
`else
   localparam logic        EXP_BR_PRED = 1'b0;
   localparam logic [31:0] EXP_BR_NEXT = 32'h0000_0044;
   localparam logic [7:0]  EXP_BR_IDX  = 8'h00;
`endif

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic respond(input logic [31:0] inst, input logic taken);
      bus.icache_valid = 1'b1;
      bus.icache_inst  = inst;
      bus.bht_taken    = taken;
      step();
      bus.icache_valid = 1'b0;
      bus.icache_inst  = 32'd0;
      bus.bht_taken    = 1'b0;
   endtask

   task automatic do_flush(input logic [31:0] target);
      bus.flush    = 1'b1;
      bus.flush_pc = target;
      step();
      bus.flush    = 1'b0;
   endtask

   task automatic test_reset();
      bus.flush = 1'b1; bus.flush_pc = 32'h0000_0500;
      step(); step();
      n_cmp++; if (bus.icache_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %0b want 0", bus.icache_req); end
      n_cmp++; if (bus.icache_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr got %h want 0", bus.icache_addr); end
      n_cmp++; if (bus.iq_valid !== 1'b0 || bus.iq_inst !== 32'h0 || bus.iq_pc !== 32'h0 || bus.iq_pred_taken !== 1'b0) begin
         n_fail++; $display("FAIL rst_iq got v=%0b i=%h p=%h t=%0b want all 0", bus.iq_valid, bus.iq_inst, bus.iq_pc, bus.iq_pred_taken); end
      bus.flush = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_addi();
      step();
      n_cmp++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h0) begin
         n_fail++; $display("FAIL first_req got req=%0b addr=%h want 1/0", bus.icache_req, bus.icache_addr); end
      respond(32'h0000_0013, 1'b0);
      n_cmp++; if (bus.iq_valid !== 1'b1 || bus.iq_inst !== 32'h13 || bus.iq_pc !== 32'h0 || bus.iq_pred_taken !== 1'b0) begin
         n_fail++; $display("FAIL addi_entry got v=%0b i=%h p=%h t=%0b want 1/13/0/0", bus.iq_valid, bus.iq_inst, bus.iq_pc, bus.iq_pred_taken); end
      n_cmp++; if (bus.icache_req !== 1'b0) begin n_fail++; $display("FAIL addi_req_drop got %0b want 0", bus.icache_req); end
      step();
      n_cmp++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h4) begin
         n_fail++; $display("FAIL addi_next got req=%0b addr=%h want 1/4", bus.icache_req, bus.icache_addr); end
   endtask

   task automatic test_jal();
      do_flush(32'h0000_0010);
      n_cmp++; if (bus.iq_valid !== 1'b0 || bus.icache_req !== 1'b0) begin
         n_fail++; $display("FAIL flush_clear got v=%0b req=%0b want 0/0", bus.iq_valid, bus.icache_req); end
      step();
      n_cmp++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h10) begin
         n_fail++; $display("FAIL flush_req got req=%0b addr=%h want 1/10", bus.icache_req, bus.icache_addr); end
      respond(32'h0100_006F, 1'b0);
      n_cmp++; if (bus.iq_inst !== 32'h0100_006F || bus.iq_pc !== 32'h10 || bus.iq_pred_taken !== 1'b1) begin
         n_fail++; $display("FAIL jal_entry got i=%h p=%h t=%0b want 0100006f/10/1", bus.iq_inst, bus.iq_pc, bus.iq_pred_taken); end
      step();
      n_cmp++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h20) begin
         n_fail++; $display("FAIL jal_target got req=%0b addr=%h want 1/20", bus.icache_req, bus.icache_addr); end
   endtask

   task automatic test_branch();
      do_flush(32'h0000_0040);
      step();
      n_cmp++; if (bus.icache_addr !== 32'h40 || bus.bht_index !== EXP_BR_IDX) begin
         n_fail++; $display("FAIL br_index got addr=%h idx=%h want 40/%h", bus.icache_addr, bus.bht_index, EXP_BR_IDX); end
      respond(32'hFE00_0EE3, 1'b1);
      n_cmp++; if (bus.iq_pc !== 32'h40 || bus.iq_pred_taken !== EXP_BR_PRED) begin
         n_fail++; $display("FAIL br_entry got p=%h t=%0b want 40/%0b", bus.iq_pc, bus.iq_pred_taken, EXP_BR_PRED); end
      step();
      n_cmp++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== EXP_BR_NEXT) begin
         n_fail++; $display("FAIL br_next got req=%0b addr=%h want 1/%h", bus.icache_req, bus.icache_addr, EXP_BR_NEXT); end
   endtask

   task automatic test_jalr();
      int seen_req;
      do_flush(32'h0000_0008);
      step();
      respond(32'h0000_8067, 1'b0);
      n_cmp++; if (bus.iq_valid !== 1'b1 || bus.iq_pc !== 32'h8 || bus.iq_pred_taken !== 1'b0) begin
         n_fail++; $display("FAIL jalr_entry got v=%0b p=%h t=%0b want 1/8/0", bus.iq_valid, bus.iq_pc, bus.iq_pred_taken); end
      seen_req = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.icache_req !== 1'b0) seen_req++;
         step();
      end
      n_cmp++; if (seen_req != 0) begin n_fail++; $display("FAIL jalr_block got %0d req cycles want 0", seen_req); end
      do_flush(32'h0000_0100);
      n_cmp++; if (bus.icache_req !== 1'b0) begin n_fail++; $display("FAIL jalr_flush1 got req=%0b want 0", bus.icache_req); end
      step();
      n_cmp++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h100) begin
         n_fail++; $display("FAIL jalr_flush2 got req=%0b addr=%h want 1/100", bus.icache_req, bus.icache_addr); end
   endtask

   task automatic test_full();
      int bad;
      do_flush(32'h0000_0000);
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'(4 * i)) bad++;
         respond(32'h0000_0013, 1'b0);
      end
      n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL fill_reqs got %0d bad requests want 0", bad); end
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bus.icache_req !== 1'b0) bad++;
      end
      n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL full_stall got %0d req cycles want 0", bad); end
      bus.iq_ready = 1'b1;
      step();
      bus.iq_ready = 1'b0;
      n_cmp++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h20 || bus.iq_pc !== 32'h4) begin
         n_fail++; $display("FAIL pop_release got req=%0b addr=%h head=%h want 1/20/4", bus.icache_req, bus.icache_addr, bus.iq_pc); end
      respond(32'h0000_0013, 1'b0);
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (bus.icache_req !== 1'b0) bad++;
      end
      n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL refull_stall got %0d req cycles want 0", bad); end
      bus.iq_ready = 1'b1;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.iq_valid !== 1'b1 || bus.iq_pc !== 32'(4 + 4 * i)) bad++;
         step();
      end
      bus.iq_ready = 1'b0;
      n_cmp++; if (bad != 0 || bus.iq_valid !== 1'b0) begin
         n_fail++; $display("FAIL drain got %0d bad entries v=%0b want 0/0", bad, bus.iq_valid); end
   endtask

   task automatic test_flush_valid();
      do_flush(32'h0000_0200);
      for (int i = 0; i < 3; i++) begin
         step();
         respond(32'h0000_0013, 1'b0);
      end
      step();
      bus.icache_valid = 1'b1; bus.icache_inst = 32'h0000_0013;
      bus.flush = 1'b1; bus.flush_pc = 32'h0000_0300;
      step();
      bus.icache_valid = 1'b0; bus.flush = 1'b0;
      n_cmp++; if (bus.iq_valid !== 1'b0 || bus.icache_req !== 1'b0) begin
         n_fail++; $display("FAIL flush_valid got v=%0b req=%0b want 0/0", bus.iq_valid, bus.icache_req); end
      step();
      n_cmp++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h300) begin
         n_fail++; $display("FAIL flush_valid_req got req=%0b addr=%h want 1/300", bus.icache_req, bus.icache_addr); end
      respond(32'h0000_0013, 1'b0);
      n_cmp++; if (bus.iq_valid !== 1'b1 || bus.iq_pc !== 32'h300) begin
         n_fail++; $display("FAIL no_stale got v=%0b p=%h want 1/300", bus.iq_valid, bus.iq_pc); end
   endtask

   task automatic test_rdy();
      rdy = 1'b0; bus.iq_ready = 1'b1;
      step(); step();
      n_cmp++; if (bus.iq_valid !== 1'b1 || bus.icache_req !== 1'b0) begin
         n_fail++; $display("FAIL rdy_freeze got v=%0b req=%0b want 1/0", bus.iq_valid, bus.icache_req); end
      rdy = 1'b1;
      step();
      bus.iq_ready = 1'b0;
      n_cmp++; if (bus.iq_valid !== 1'b0 || bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h304) begin
         n_fail++; $display("FAIL rdy_resume got v=%0b req=%0b addr=%h want 0/1/304", bus.iq_valid, bus.icache_req, bus.icache_addr); end
      rdy = 1'b0;
      respond(32'h0000_0013, 1'b0);
      rdy = 1'b1;
      n_cmp++; if (bus.iq_valid !== 1'b0 || bus.icache_req !== 1'b1) begin
         n_fail++; $display("FAIL rdy_ignore_valid got v=%0b req=%0b want 0/1", bus.iq_valid, bus.icache_req); end
   endtask

   initial begin
      bus.icache_valid = 1'b0;
      bus.icache_inst  = 32'd0;
      bus.bht_taken    = 1'b0;
      bus.iq_ready     = 1'b0;
      bus.flush        = 1'b0;
      bus.flush_pc     = 32'd0;
      test_reset();
      test_addi();
      test_jal();
      test_branch();
      test_jalr();
      test_full();
      test_flush_valid();
      test_rdy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
